// File: rtl/native2axis_pkg.sv
// Shared types and defaults for the native-video to AXI4-Stream capture path.
// Holds the capture FSM encoding and the vsync polarity helper.
package native2axis_pkg;

  localparam int unsigned N2A_DATA_W_DEF     = 24;
  localparam int unsigned N2A_FIFO_DEPTH_DEF = 1024;
  localparam int unsigned N2A_CNT_W_DEF      = 12;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    PASS    = 2'd1,
    DROP    = 2'd2
  } n2a_state_e;

  function automatic logic level_active(input logic level, input logic pol);
    return level == pol;
  endfunction

endpackage

// File: rtl/native2axis_if.sv
// AXI4-Stream video bundle: tuser = start of frame, tlast = end of line.
interface native2axis_if #(
  parameter int DATA_W = 24
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/native2axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output stage.
// The output register is one of the DEPTH slots, so total capacity is exactly DEPTH.
module native2axis_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      mem_cnt;
  logic             out_valid;

  logic pop, push, load, bypass, mem_wr, mem_rd;

  assign full   = (mem_cnt + (AW+1)'(out_valid)) == (AW+1)'(DEPTH);
  assign empty  = ~out_valid;
  assign pop    = out_valid & rd_en;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push   = wr_en & (~full | pop);
  assign load   = ~out_valid | pop;
  assign bypass = push & load & (mem_cnt == '0);
  assign mem_wr = push & ~bypass;
  assign mem_rd = load & (mem_cnt != '0);

  // NOTE: storage array has no reset; only pointers and flags define FIFO contents.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (load) begin
        if (mem_rd) begin
          rd_data   <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (bypass) begin
          rd_data   <= wr_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/native2axis.sv
// Native timing video to AXI4-Stream capture: lookahead stage derives tlast, a FIFO
// absorbs backpressure, and an overflow drops the remainder of the frame.
module native2axis
  import native2axis_pkg::*;
#(
  parameter int DATA_W     = N2A_DATA_W_DEF,
  parameter int FIFO_DEPTH = N2A_FIFO_DEPTH_DEF,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int CNT_W      = N2A_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               natv_active,
  input  logic               natv_hsync,
  input  logic               natv_vsync,
  input  logic [DATA_W-1:0]  natv_data,
  native2axis_if.master      m_axis,
  output logic               ovf_flag,
  input  logic               ovf_clr,
  output logic [CNT_W-1:0]   line_pixels,
  output logic [CNT_W-1:0]   frame_lines
);

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] data;
  } vid_beat_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  n2a_state_e state, state_nxt;

  logic              vs_prev, vs_act, vs_edge;
  logic              hold_valid, hold_tuser;
  logic [DATA_W-1:0] hold_data;
  logic              sof_pend;
  logic              eol, pass_en, push_req, drop;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_accept, fifo_wr;
  logic [CNT_W-1:0]  pix_cnt, line_cnt, line_total;
  vid_beat_t         fifo_in, fifo_out;
  logic              hsync_unused;

  assign hsync_unused = natv_hsync;

  assign vs_act  = level_active(natv_vsync, VSYNC_POL);
  assign vs_edge = vs_act & ~vs_prev;

  // The held pixel ends its line when no pixel follows it or a new frame begins.
  assign eol         = hold_valid & (~natv_active | vs_edge);
  assign fifo_pop    = ~fifo_empty & m_axis.tready;
  assign fifo_accept = ~fifo_full | fifo_pop;
  assign push_req    = hold_valid & pass_en;
  assign fifo_wr     = push_req & fifo_accept;
  assign drop        = push_req & ~fifo_accept;
  assign fifo_in     = '{tuser: hold_tuser, tlast: eol, data: hold_data};
  assign line_total  = eol ? sat_inc(line_cnt) : line_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_VS;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_VS: if (vs_edge) state_nxt = PASS;
      PASS:    if (vs_edge) state_nxt = PASS;
               else if (drop) state_nxt = DROP;
      DROP:    if (vs_edge) state_nxt = PASS;
      default: state_nxt = WAIT_VS;
    endcase
  end

  always_comb begin
    pass_en = (state == PASS);
  end

  // vs_prev starts active so a vsync already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev    <= 1'b1;
      hold_valid <= 1'b0;
      hold_tuser <= 1'b0;
      hold_data  <= '0;
      sof_pend   <= 1'b0;
    end else begin
      vs_prev    <= vs_act;
      hold_valid <= natv_active;
      if (natv_active) begin
        hold_data  <= natv_data;
        hold_tuser <= sof_pend | vs_edge;
        sof_pend   <= 1'b0;
      end else if (vs_edge) begin
        sof_pend   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_pixels <= '0;
      frame_lines <= '0;
    end else begin
      if (hold_valid) begin
        if (eol) begin
          line_pixels <= sat_inc(pix_cnt);
          pix_cnt     <= '0;
        end else begin
          pix_cnt     <= sat_inc(pix_cnt);
        end
      end
      if (vs_edge) begin
        if (line_total != '0) frame_lines <= line_total;
        line_cnt <= '0;
      end else begin
        line_cnt <= line_total;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_flag <= 1'b0;
    else if (drop)    ovf_flag <= 1'b1;
    else if (ovf_clr) ovf_flag <= 1'b0;
  end

  native2axis_sync_fifo #(
    .WIDTH ($bits(vid_beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_in),
    .rd_en   (m_axis.tready),
    .rd_data (fifo_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = fifo_out.data;
  assign m_axis.tuser  = fifo_out.tuser;
  assign m_axis.tlast  = fifo_out.tlast;

endmodule

// File: tb/tb_native2axis.sv
// Self-checking bench for native2axis: frame table, randomized backpressure against
// a frame-level beat model, overflow and reset corner sequences.
module tb_native2axis;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 12;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct {
    int lines;
    int px;
    int hblank;
    int exp_lp;
    int exp_fl;
  } frame_vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              natv_active = 1'b0;
  logic              natv_hsync = 1'b0;
  logic              natv_vsync = 1'b0;
  logic [DATA_W-1:0] natv_data = '0;
  logic              ovf_clr = 1'b0;
  logic              ovf_flag;
  logic [CNT_W-1:0]  line_pixels, frame_lines;

  native2axis_if #(.DATA_W(DATA_W)) axis ();

  native2axis #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .VSYNC_POL  (1'b1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .natv_active (natv_active),
    .natv_hsync  (natv_hsync),
    .natv_vsync  (natv_vsync),
    .natv_data   (natv_data),
    .m_axis      (axis),
    .ovf_flag    (ovf_flag),
    .ovf_clr     (ovf_clr),
    .line_pixels (line_pixels),
    .frame_lines (frame_lines)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                errors = 0;
  int                beats_seen = 0;
  beat_t             exp_q[$];
  bit                rdy_rand = 1'b0;
  bit                rdy_val = 1'b1;
  bit                rand_data = 1'b0;
  logic [DATA_W-1:0] data_cnt = '0;
  frame_vec_t        vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stream monitor: scoreboard compare on each handshake plus AXIS stability rules.
  beat_t mon_beat, prev_beat;
  bit    prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      mon_beat = {axis.tuser, axis.tlast, axis.tdata};
      if (prev_stall) begin
        check("stall_tvalid", 64'(axis.tvalid), 64'd1);
        check("stall_beat", 64'(mon_beat), 64'(prev_beat));
      end
      if (axis.tvalid && axis.tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", mon_beat);
        end else begin
          check("beat", 64'(mon_beat), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_beat  = mon_beat;
    end
  end

  task automatic step(input bit act, input bit vs, input logic [DATA_W-1:0] d);
    @(posedge clk);
    #1;
    natv_active = act;
    natv_vsync  = vs;
    natv_hsync  = ~act;
    natv_data   = act ? d : DATA_W'($urandom);
    axis.tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
  endtask

  // Reference model: every pixel of an accepted frame becomes one beat, SOF on the
  // first pixel of the frame, EOL on the last pixel of each line.
  task automatic send_frame(input int lines, input int px, input int hblank, input bit expect_it);
    logic [DATA_W-1:0] d;
    vs_pulse();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) begin
        d = rand_data ? DATA_W'($urandom) : data_cnt;
        data_cnt++;
        if (expect_it) exp_q.push_back(beat_t'{tuser: (l == 0 && p == 0), tlast: (p == px - 1), data: d});
        step(1'b1, 1'b0, d);
      end
      for (int h = 0; h < hblank; h++) step(1'b0, 1'b0, '0);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    vecs[0] = '{lines: 4, px: 8, hblank: 2, exp_lp: 8, exp_fl: 4};
    vecs[1] = '{lines: 2, px: 5, hblank: 1, exp_lp: 5, exp_fl: 2};
    vecs[2] = '{lines: 1, px: 1, hblank: 3, exp_lp: 1, exp_fl: 1};
    vecs[3] = '{lines: 3, px: 1, hblank: 1, exp_lp: 1, exp_fl: 3};
    axis.tready = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      natv_active = 1'($urandom);
      natv_vsync  = 1'($urandom);
      natv_hsync  = 1'($urandom);
      natv_data   = DATA_W'($urandom);
      ovf_clr     = 1'($urandom);
      axis.tready = 1'($urandom);
      check("rst_tvalid", 64'(axis.tvalid), 64'd0);
      check("rst_ovf", 64'(ovf_flag), 64'd0);
      check("rst_line_pixels", 64'(line_pixels), 64'd0);
      check("rst_frame_lines", 64'(frame_lines), 64'd0);
    end
    natv_active = 1'b0;
    natv_vsync  = 1'b0;
    ovf_clr     = 1'b0;
    rst_n       = 1'b1;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Frame table with tready=1: beat stream, line_pixels, then frame_lines after vs_edge.
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].lines, vecs[v].px, vecs[v].hblank, 1'b1);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      check("tbl_line_pixels", 64'(line_pixels), 64'(vecs[v].exp_lp));
      vs_pulse();
      check("tbl_frame_lines", 64'(frame_lines), 64'(vecs[v].exp_fl));
      wait_drain(100);
    end

    // Reset released mid-frame: nothing until the first vs_edge.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    base  = beats_seen;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 8; p++) begin
        step(1'b1, 1'b0, data_cnt);
        data_cnt++;
        if (l == 0 && p == 3) rst_n = 1'b1;
      end
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
    end
    step(1'b0, 1'b0, '0);
    check("midframe_no_beats", 64'(beats_seen), 64'(base));
    send_frame(2, 6, 2, 1'b1);
    wait_drain(100);

    // Random data and 50% tready, three frames against the model.
    rdy_rand  = 1'b1;
    rand_data = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(3, 8, 8, 1'b1);
      wait_drain(400);
    end
    check("rand_ovf", 64'(ovf_flag), 64'd0);
    check("rand_line_pixels", 64'(line_pixels), 64'd8);
    vs_pulse();
    check("rand_frame_lines", 64'(frame_lines), 64'd3);
    wait_drain(50);

    // Overflow: tready held low across a 2x16 frame; the 17th push fails.
    rdy_rand  = 1'b0;
    rand_data = 1'b0;
    rdy_val   = 1'b0;
    vs_pulse();
    for (int p = 0; p < 16; p++) begin
      exp_q.push_back(beat_t'{tuser: (p == 0), tlast: (p == 15), data: data_cnt});
      step(1'b1, 1'b0, data_cnt);
      data_cnt++;
    end
    step(1'b0, 1'b0, '0);
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 1'b0, data_cnt);
      data_cnt++;
      if (p == 1) check("ovf_before_17th", 64'(ovf_flag), 64'd0);
      if (p == 2) check("ovf_at_17th", 64'(ovf_flag), 64'd1);
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    base    = beats_seen;
    rdy_val = 1'b1;
    wait_drain(100);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
    check("ovf_drained_beats", 64'(beats_seen - base), 64'd16);
    check("ovf_sticky", 64'(ovf_flag), 64'd1);
    send_frame(2, 8, 2, 1'b1);
    wait_drain(100);
    ovf_clr = 1'b1;
    step(1'b0, 1'b0, '0);
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(ovf_flag), 64'd0);

    // Async reset pulse while tvalid is high.
    rdy_val = 1'b0;
    vs_pulse();
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 1'b0, data_cnt);
      data_cnt++;
    end
    step(1'b0, 1'b0, '0);
    check("pre_rst_tvalid", 64'(axis.tvalid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 64'(axis.tvalid), 64'd0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    rst_n   = 1'b1;
    rdy_val = 1'b1;
    base    = beats_seen;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    check("post_rst_empty", 64'(axis.tvalid), 64'd0);
    check("post_rst_no_beats", 64'(beats_seen), 64'(base));
    send_frame(2, 4, 1, 1'b1);
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
